qdense_neuron_engine: RTL

// - Hardware consumer of the int8 quantized dense-layer dataflow that the MNIST benches drive in software.
// - Accepts a stream of (activation, weight) byte pairs for one output neuron.
// - Subtracts zero-points, multiplies exactly (16x16->32 signed) and accumulates; on the last beat adds the int32 bias.
// - Applies optional ReLU, requantizes with (mult, shift) and emits one int8 output byte per neuron.
// - Sits between the layer memory reader and the output byte writer.

---
 rtl/qdense_neuron_engine_if.sv | 25 ++
 rtl/qdense_neuron_engine.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/qdense_neuron_engine_if.sv
// Beat stream into, and requantized byte stream out of, qdense_neuron_engine.
// master = layer reader / byte writer side, slave = the engine.
interface qdense_neuron_engine_if #(
  parameter int ACC_W = 32
);
  logic             i_s_valid;
  logic             o_s_ready;
  logic [7:0]       i_s_act;
  logic [7:0]       i_s_w;
  logic             i_s_last;
  logic [ACC_W-1:0] i_s_bias;
  logic             o_m_valid;
  logic             i_m_ready;
  logic [7:0]       o_m_data;

  modport master (
    output i_s_valid, i_s_act, i_s_w, i_s_last, i_s_bias, i_m_ready,
    input  o_s_ready, o_m_valid, o_m_data
  );

  modport slave (
    input  i_s_valid, i_s_act, i_s_w, i_s_last, i_s_bias, i_m_ready,
    output o_s_ready, o_m_valid, o_m_data
  );
endinterface

// File: rtl/qdense_neuron_engine.sv
// int8 quantized dense-layer neuron: zero-point MAC, bias, optional ReLU, requantize to one byte.
// Define SAT_OUT_EN to clamp the output to [-128, 127] instead of truncating to 8 bits.
module qdense_neuron_engine #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_valid,
  input  logic [7:0]            i_in_zp,
  input  logic [7:0]            i_w_zp,
  input  logic [7:0]            i_out_zp,
  input  logic [31:0]           i_qmult,
  input  logic [31:0]           i_qshift,
  input  logic                  i_linear,
  qdense_neuron_engine_if.slave bus,
  output logic [CNT_W-1:0]      o_neuron_cnt
);
  localparam int P_W  = ACC_W + 32;
  localparam int SH_W = $clog2(P_W);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, REQ, OUT} state_t;
  state_t state;

  logic signed [7:0]       in_zp_r, w_zp_r, out_zp_r;
  logic signed [31:0]      qmult_r, qshift_r;
  logic                    linear_r;
  logic signed [ACC_W-1:0] acc, bias_r, relu_r;
  logic signed [31:0]      prod;
  logic                    prod_vld, prod_first;

  logic                    cfg_load, beat;
  logic signed [7:0]       in_zp_eff, w_zp_eff;
  logic signed [15:0]      a16, b16;
  logic signed [31:0]      prod_next;
  logic signed [ACC_W-1:0] prod_ext, acc_f, relu;

  logic signed [31:0]      tshift;
  logic [SH_W-1:0]         sh;
  logic signed [P_W-1:0]   rnd, p_full, r_full, out_sum;
  logic [7:0]              out_byte;

  assign cfg_load = i_cfg_valid && (state == IDLE);
  assign beat     = bus.i_s_valid && bus.o_s_ready;

  // A beat arriving with a config load must already see the new zero-points.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults first), otherwise a latch is inferred.
    in_zp_eff = cfg_load ? i_in_zp : in_zp_r;
    w_zp_eff  = cfg_load ? i_w_zp  : w_zp_r;
    a16       = {{8{bus.i_s_act[7]}}, bus.i_s_act} - {{8{in_zp_eff[7]}}, in_zp_eff};
    b16       = {{8{bus.i_s_w[7]}},   bus.i_s_w}   - {{8{w_zp_eff[7]}},  w_zp_eff};
    prod_next = 32'(a16) * 32'(b16);
    prod_ext  = ACC_W'(prod);
    acc_f     = (prod_first ? '0 : acc) + prod_ext + bias_r;
    relu      = (linear_r || !acc_f[ACC_W-1]) ? acc_f : '0;
  end

  // Requantize: round-half-up then arithmetic shift by 31 - qshift (clamped to the product width).
  always_comb begin
    tshift = 32'sd31 - qshift_r;
    if (tshift < 0)              sh = '0;
    else if (tshift > P_W - 1)   sh = SH_W'(P_W - 1);
    else                         sh = tshift[SH_W-1:0];
    rnd = '0;
    if (sh != '0) rnd[sh - SH_W'(1)] = 1'b1;
    p_full  = P_W'(relu_r) * P_W'(qmult_r) + rnd;
    r_full  = p_full >>> sh;
    out_sum = r_full + P_W'(out_zp_r);
`ifdef SAT_OUT_EN
    if (out_sum > P_W'(127))       out_byte = 8'h7F;
    else if (out_sum < P_W'(-128)) out_byte = 8'h80;
    else                           out_byte = out_sum[7:0];
`else
    out_byte = out_sum[7:0];
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      in_zp_r       <= '0;
      w_zp_r        <= '0;
      out_zp_r      <= '0;
      qmult_r       <= '0;
      qshift_r      <= '0;
      linear_r      <= 1'b0;
      acc           <= '0;
      bias_r        <= '0;
      relu_r        <= '0;
      prod          <= '0;
      prod_vld      <= 1'b0;
      prod_first    <= 1'b0;
      bus.o_s_ready <= 1'b1;
      bus.o_m_valid <= 1'b0;
      bus.o_m_data  <= '0;
      o_neuron_cnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (cfg_load) begin
        in_zp_r  <= i_in_zp;
        w_zp_r   <= i_w_zp;
        out_zp_r <= i_out_zp;
        qmult_r  <= i_qmult;
        qshift_r <= i_qshift;
        linear_r <= i_linear;
      end
      prod_vld <= beat;
      if (beat) begin
        prod       <= prod_next;
        prod_first <= (state == IDLE);
      end
      if (beat && bus.i_s_last) bias_r <= bus.i_s_bias;

      case (state)
        IDLE, ACC: begin
          if (prod_vld) acc <= prod_first ? prod_ext : acc + prod_ext;
          if (beat) begin
            if (bus.i_s_last) begin
              state         <= DRAIN;
              bus.o_s_ready <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        DRAIN: begin
          relu_r <= relu;
          acc    <= '0;
          state  <= REQ;
        end
        REQ: begin
          bus.o_m_data  <= out_byte;
          bus.o_m_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.i_m_ready) begin
            bus.o_m_valid <= 1'b0;
            bus.o_s_ready <= 1'b1;
            o_neuron_cnt  <= o_neuron_cnt + CNT_W'(1);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
